// File: rtl/bolge_sched.sv
// Round-robin time-share of the region decoder among four zones; drives registered Y/G/R selects.
// Latency: request seen in IDLE is granted on the next edge; each grant lasts DWELL (+hold) cycles, then GAP guard cycles.
// Backpressure: none; hold stretches the current grant, dropping the granted request releases it early.
module bolge_sched #(
    parameter int DWELL = 8,
    parameter int GAP   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [1:0] ovr,
    input  logic       hold,
    output logic       y,
    output logic [1:0] g,
    output logic [1:0] r,
    output logic       grant_valid,
    output logic       done
);

    localparam int MAXV = (DWELL > GAP) ? DWELL : GAP;
    localparam int CW   = $clog2(MAXV + 1);
    localparam logic [CW-1:0] DWELL_LD = CW'(DWELL - 1);
    // With no guard gap the GAP state is never entered, so its reload value is irrelevant.
    localparam logic [CW-1:0] GAP_LD   = (GAP > 0) ? CW'(GAP - 1) : '0;
    localparam bit            GAP_EN   = (GAP > 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_GAP
    } state_t;

    state_t          r_state;
    logic [1:0]      r_ptr;
    logic [CW-1:0]   r_cnt;
    logic            r_y;
    logic [1:0]      r_g;
    logic [1:0]      r_r;
    logic            r_gv;
    logic            r_done;

    logic [1:0]      w_pick;
    logic [1:0]      w_idx;
    logic            w_any;
    logic            w_leave;
    logic            w_gap_end;
    logic            w_post;
    logic            w_enter;
    logic            w_to_idle;

    // Round-robin pick: first requesting zone starting at r_ptr; highest offset is scanned first so the nearest wins.
    always_comb begin
        w_pick = r_ptr;
        w_idx  = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            w_idx = r_ptr + 2'(k);
            if (req[w_idx]) begin
                w_pick = w_idx;
            end
        end
    end

    // Transition decisions; early release outranks hold, hold outranks dwell expiry.
    always_comb begin
        w_any     = |req;
        w_leave   = (r_state == ST_GRANT) && (!req[r_g] || (!hold && (r_cnt == '0)));
        w_gap_end = (r_state == ST_GAP) && (r_cnt == '0);
        // Without a guard gap the post-gap decision happens on the same edge the grant ends.
        w_post    = w_gap_end || (w_leave && !GAP_EN);
        w_enter   = ((r_state == ST_IDLE) || w_post) && w_any;
        w_to_idle = w_post && !w_any;
    end

    // Scheduler FSM with all decoder selects and status outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= 2'd0;
            r_cnt   <= '0;
            r_y     <= 1'b0;
            r_g     <= 2'd0;
            r_r     <= 2'd0;
            r_gv    <= 1'b0;
            r_done  <= 1'b0;
        end else if (w_enter) begin
            // New grant; done still pulses here when a GAP-less grant ends on this edge.
            r_state <= ST_GRANT;
            r_g     <= w_pick;
            r_r     <= ovr;
            r_y     <= 1'b1;
            r_gv    <= 1'b1;
            r_cnt   <= DWELL_LD;
            r_ptr   <= w_pick + 2'd1;
            r_done  <= w_leave;
        end else if (w_to_idle) begin
            r_state <= ST_IDLE;
            r_y     <= 1'b0;
            r_r     <= 2'd0;
            r_gv    <= 1'b0;
            r_cnt   <= '0;
            r_done  <= w_leave;
        end else if (w_leave) begin
            // Only reachable with a guard gap: y stays high and g keeps the last zone.
            r_state <= ST_GAP;
            r_cnt   <= GAP_LD;
            r_r     <= 2'd0;
            r_gv    <= 1'b0;
            r_done  <= 1'b1;
        end else begin
            r_done <= 1'b0;
            if (((r_state == ST_GRANT) && !hold) || (r_state == ST_GAP)) begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    assign y           = r_y;
    assign g           = r_g;
    assign r           = r_r;
    assign grant_valid = r_gv;
    assign done        = r_done;

endmodule

// File: tb/tb_bolge_sched.sv
// Bench for bolge_sched: a GAP=2 instance and a GAP=0 instance driven by directed vectors.
// Expected grants (zone, R value, length, done spacing) are queued when stimulus is applied.
// A negedge monitor checks every granted cycle against the queue head and pops on each done pulse.
module tb_bolge_sched;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req0  = 4'd0;
    logic [3:0] req1  = 4'd0;
    logic [1:0] ovr   = 2'd0;
    logic       hold  = 1'b0;

    logic       y0, gv0, done0;
    logic [1:0] g0, r0;
    logic       y1, gv1, done1;
    logic [1:0] g1, r1;

    always #5 clk = ~clk;

    bolge_sched #(.DWELL(8), .GAP(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .ovr(ovr), .hold(hold),
        .y(y0), .g(g0), .r(r0), .grant_valid(gv0), .done(done0)
    );

    bolge_sched #(.DWELL(8), .GAP(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .ovr(ovr), .hold(hold),
        .y(y1), .g(g1), .r(r1), .grant_valid(gv1), .done(done1)
    );

    typedef struct {
        int g;
        int r;
        int len;
        int dint;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    int   errors = 0;
    int   checks = 0;

    int   run_len    [2];
    int   since_done [2];
    bit   prev_gv    [2];

    function automatic exp_t mk(input int g, input int r, input int len, input int dint);
        exp_t e;
        e.g = g; e.r = r; e.len = len; e.dint = dint;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mon_step(input int k, input logic gv, input logic y, input logic dn,
                            input logic [1:0] g, input logic [1:0] r);
        exp_t e;
        bit   have;
        since_done[k]++;
        if (dn) begin
            have = 1'b0;
            if (k == 0 && sb0.size() > 0) begin e = sb0.pop_front(); have = 1'b1; end
            if (k == 1 && sb1.size() > 0) begin e = sb1.pop_front(); have = 1'b1; end
            if (!have) begin
                checks++; errors++;
                $display("FAIL u%0d_unexpected_done: done pulsed with no grant expected at %0t", k, $time);
            end else begin
                chk($sformatf("u%0d_len_zone%0d", k, e.g), run_len[k], e.len);
                if (e.dint > 0) chk($sformatf("u%0d_done_spacing", k), since_done[k], e.dint);
            end
            since_done[k] = 0;
        end
        if (gv) begin
            have = 1'b0;
            if (k == 0 && sb0.size() > 0) begin e = sb0[0]; have = 1'b1; end
            if (k == 1 && sb1.size() > 0) begin e = sb1[0]; have = 1'b1; end
            if (!have) begin
                checks++; errors++;
                $display("FAIL u%0d_unexpected_grant: g=%0d with no grant expected at %0t", k, g, $time);
            end else begin
                chk($sformatf("u%0d_grant_g", k), g, e.g);
                chk($sformatf("u%0d_grant_r", k), r, e.r);
                chk($sformatf("u%0d_grant_y", k), y, 1);
            end
            if (!prev_gv[k] || dn) run_len[k] = 1;
            else                   run_len[k]++;
        end
        if (!gv && y) chk($sformatf("u%0d_gap_r", k), r, 0);
        prev_gv[k] = gv;
    endtask

    // Monitor: independent of stimulus, samples on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                prev_gv[k]    = 1'b0;
                since_done[k] = 0;
                run_len[k]    = 0;
            end
        end else begin
            mon_step(0, gv0, y0, done0, g0, r0);
            mon_step(1, gv1, y1, done1, g1, r1);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t tmp;

        // Reset held with every zone requesting.
        req0 = 4'b1111;
        ovr  = 2'b01;
        tick(3);
        chk("rst_y",    y0,    0);
        chk("rst_g",    g0,    0);
        chk("rst_r",    r0,    0);
        chk("rst_gv",   gv0,   0);
        chk("rst_done", done0, 0);
        chk("rst_y1",   y1,    0);

        // Fairness: 0,1,2,3,0 with 8-cycle grants and done every 10 cycles.
        sb0.push_back(mk(0, 1, 8, 0));
        sb0.push_back(mk(1, 1, 8, 10));
        sb0.push_back(mk(2, 1, 8, 10));
        sb0.push_back(mk(3, 1, 8, 10));
        sb0.push_back(mk(0, 1, 8, 10));
        rst_n = 1'b1;
        tick(1);
        chk("latency_gv", gv0, 1);
        chk("latency_g",  g0,  0);
        tick(48);
        req0 = 4'b0000;
        tick(5);
        chk("fair_idle_y",  y0,  0);
        chk("fair_idle_gv", gv0, 0);

        // Hold for 3 cycles stretches zone 2 to 11 cycles; ovr change mid-grant only affects the next grant.
        req0 = 4'b0100;
        ovr  = 2'b10;
        sb0.push_back(mk(2, 2, 11, 0));
        sb0.push_back(mk(2, 3, 8, 10));
        tick(3);
        hold = 1'b1;
        tick(3);
        hold = 1'b0;
        ovr  = 2'b11;
        tick(16);
        req0 = 4'b0000;
        tick(4);
        chk("hold_idle_y", y0, 0);

        // Early release on the 3rd grant cycle, with hold asserted.
        req0 = 4'b0010;
        ovr  = 2'b01;
        sb0.push_back(mk(1, 1, 3, 0));
        tick(3);
        req0 = 4'b0000;
        hold = 1'b1;
        tick(1);
        chk("early_done", done0, 1);
        chk("early_gv",   gv0,   0);
        chk("early_gap_y", y0,   1);
        tick(4);
        chk("early_idle_y", y0, 0);
        hold = 1'b0;

        // Asynchronous reset in the middle of a zone 3 grant.
        req0 = 4'b1000;
        ovr  = 2'b10;
        sb0.push_back(mk(3, 2, 0, 0));
        tick(3);
        chk("z3_gv", gv0, 1);
        chk("z3_g",  g0,  3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_y",    y0,    0);
        chk("arst_g",    g0,    0);
        chk("arst_r",    r0,    0);
        chk("arst_gv",   gv0,   0);
        chk("arst_done", done0, 0);
        tmp = sb0.pop_front();
        tick(2);
        req0 = 4'b1010;
        sb0.push_back(mk(1, 2, 8, 0));
        sb0.push_back(mk(3, 2, 8, 10));
        rst_n = 1'b1;
        tick(1);
        chk("post_rst_g",  g0,  1);
        chk("post_rst_gv", gv0, 1);
        tick(18);
        req0 = 4'b0000;
        tick(5);

        // GAP=0 instance: zones 0 and 1 alternate with no gap; done lands on the new grant's first cycle.
        req1 = 4'b0011;
        ovr  = 2'b01;
        sb1.push_back(mk(0, 1, 8, 0));
        sb1.push_back(mk(1, 1, 8, 8));
        sb1.push_back(mk(0, 1, 8, 8));
        sb1.push_back(mk(1, 1, 8, 8));
        tick(9);
        chk("gap0_boundary_done", done1, 1);
        chk("gap0_boundary_gv",   gv1,   1);
        chk("gap0_boundary_g",    g1,    1);
        tick(23);
        req1 = 4'b0000;
        tick(3);
        chk("gap0_idle_gv", gv1, 0);
        chk("gap0_idle_y",  y1,  0);

        tick(2);
        chk("sb0_drained", sb0.size(), 0);
        chk("sb1_drained", sb1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
